// File: rtl/csi_raw_crop_gray.sv
// RAW8 CSI-2 beat cropper: window select, grey RGB888 expansion,
// pixel-pair FIFO and one-pixel-per-clock serializer with SOF/SOL markers.
module csi_raw_crop_gray #(
  parameter int NUM_LANES   = 2,
  parameter int NUM_RAW     = 8,
  parameter int LINE_PIXELS = 1280,
  parameter int FRAME_LINES = 720,
  parameter int CROP_X0     = 0,
  parameter int CROP_W      = 640,
  parameter int CROP_Y0     = 0,
  parameter int CROP_H      = 480,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic                         raw_valid,
  input  logic [NUM_LANES*NUM_RAW-1:0] raw_data,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [23:0]                  pix_data,
  output logic                         pix_sof,
  output logic                         pix_sol,
  output logic                         frame_done,
  output logic                         overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [15:0] X_LAST = 16'(LINE_PIXELS / 2 - 1);
  localparam logic [15:0] Y_LAST = 16'(FRAME_LINES - 1);
  localparam logic [15:0] X0     = 16'(CROP_X0);
  localparam logic [15:0] CW     = 16'(CROP_W);
  localparam logic [15:0] Y0     = 16'(CROP_Y0);
  localparam logic [15:0] CH     = 16'(CROP_H);
  localparam logic [AW:0] FULL_N = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_N  = (AW+1)'(1);

  typedef enum logic {
    F_WAIT,
    F_ACTIVE
  } fstate_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI
  } sstate_t;

  typedef struct packed {
    logic       sof;
    logic       sol;
    logic [7:0] hi;
    logic [7:0] lo;
  } entry_t;

  fstate_t     fstate, fstate_n;
  sstate_t     ser, ser_n;
  logic [15:0] x, y, x_n, y_n;
  logic [15:0] cur_x, cur_y, x2;
  logic        beat, keep, last, last_x;
  logic        in_x, in_y;

  logic        st_keep, st_sol;
  logic [15:0] st_data;
  logic        armed;

  entry_t      mem [FIFO_DEPTH];
  entry_t      head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic        full, push_ok, retire;

  // Position of the current beat; frame_start overrides to (0,0).
  always_comb begin
    cur_x    = frame_start ? '0 : x;
    cur_y    = frame_start ? '0 : y;
    beat     = raw_valid && (frame_start || fstate == F_ACTIVE);
    x2       = cur_x << 1;
    in_x     = (x2 - X0) < CW;
    in_y     = (cur_y - Y0) < CH;
    keep     = beat && in_x && in_y;
    last_x   = cur_x == X_LAST;
    last     = beat && last_x && cur_y == Y_LAST;
    fstate_n = fstate;
    x_n      = x;
    y_n      = y;
    if (frame_start) begin
      fstate_n = F_ACTIVE;
      x_n      = '0;
      y_n      = '0;
    end
    if (beat) begin
      if (last) begin
        fstate_n = F_WAIT;
        x_n      = '0;
        y_n      = '0;
      end else if (last_x) begin
        x_n = '0;
        y_n = cur_y + 16'd1;
      end else begin
        x_n = cur_x + 16'd1;
        y_n = cur_y;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fstate     <= F_WAIT;
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
      st_keep    <= 1'b0;
      st_sol     <= 1'b0;
      st_data    <= '0;
    end else begin
      fstate     <= fstate_n;
      x          <= x_n;
      y          <= y_n;
      frame_done <= last;
      st_keep    <= keep;
      st_sol     <= x2 == X0;
      st_data    <= raw_data;
    end
  end

  // Full is judged before any same-cycle retire.
  assign full    = count == FULL_N;
  assign push_ok = st_keep && !full;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= '{sof: armed, sol: st_sol,
                       hi: st_data[15:8], lo: st_data[7:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      armed    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (retire)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, retire})
        2'b10:   count <= count + ONE_N;
        2'b01:   count <= count - ONE_N;
        default: count <= count;
      endcase
      if (frame_start)  armed <= 1'b1;
      else if (push_ok) armed <= 1'b0;
      if (st_keep && full) overflow <= 1'b1;
    end
  end

  // The head entry stays counted until its high pixel is accepted.
  always_comb begin
    ser_n  = ser;
    retire = 1'b0;
    unique case (ser)
      S_IDLE: if (count != '0) ser_n = S_LO;
      S_LO:   if (pix_ready) ser_n = S_HI;
      S_HI: begin
        if (pix_ready) begin
          retire = 1'b1;
          ser_n  = (count > ONE_N) ? S_LO : S_IDLE;
        end
      end
      default: ser_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ser <= S_IDLE;
    else       ser <= ser_n;
  end

  always_comb begin
    pix_valid = ser != S_IDLE;
    pix_data  = '0;
    pix_sof   = 1'b0;
    pix_sol   = 1'b0;
    unique case (ser)
      S_LO: begin
        pix_data = {3{head.lo}};
        pix_sof  = head.sof;
        pix_sol  = head.sol;
      end
      S_HI:    pix_data = {3{head.hi}};
      default: pix_data = '0;
    endcase
  end

endmodule

// File: doc/csi_raw_crop_gray.md
Name: csi_raw_crop_gray

Overview:
- Sits directly downstream of the CSI-2 receiver, in the csi_byte_clk domain, ahead of the RAM buffer.
- Takes the receiver's unthrottled RAW8 beats (NUM_LANES pixels per beat).
- Tracks x/y position within the frame, keeps a rectangular crop window, and expands each kept RAW8 pixel to grey RGB888.
- Emits one pixel per cycle on a valid/ready stream, with start-of-frame and start-of-line markers.
- A small FIFO absorbs the rate mismatch between the 2-pixel input beats and the 1-pixel output.

Parameters:
- NUM_LANES, 2, pixels per input beat; only 2 is supported.
- NUM_RAW, 8, bits per raw pixel; only 8 is supported.
- LINE_PIXELS, 1280, active pixels per sensor line; must be even.
- FRAME_LINES, 720, active lines per frame.
- CROP_X0, 0, first kept column; must be even.
- CROP_W, 640, kept columns; must be even and non-zero; CROP_X0+CROP_W <= LINE_PIXELS.
- CROP_Y0, 0, first kept line.
- CROP_H, 480, kept lines; CROP_Y0+CROP_H <= FRAME_LINES.
- FIFO_DEPTH, 16, pixel-pair entries; must be a power of two and >= 4.

Ports:
- clk, input, 1, csi_byte_clk.
- reset, input, 1, asynchronous active-high reset.
- frame_start, input, 1, single-cycle pulse at the CSI-2 frame-start short packet.
- raw_valid, input, 1, raw_data is a valid beat.
- raw_data, input, NUM_LANES*NUM_RAW, beat; [7:0] is the earlier pixel, [15:8] the later.
- pix_valid, output, 1, pix_data holds a pixel.
- pix_ready, input, 1, consumer accepts the pixel.
- pix_data, output, 24, {R,G,B}, each channel equal to the raw byte.
- pix_sof, output, 1, first kept pixel of the frame.
- pix_sol, output, 1, first kept pixel of a line.
- frame_done, output, 1, one-cycle pulse after the last beat of line FRAME_LINES-1.
- overflow, output, 1, sticky: a kept beat was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - All outputs 0.
  - Counters x=0, y=0.
  - FIFO empty, serializer idle.
  - Frame state "waiting": no beats are kept until the first frame_start.
- Position counters:
  - x counts beats, 0..LINE_PIXELS/2-1; y counts lines, 0..FRAME_LINES-1.
  - Each raw_valid beat is processed at (x,y), then x increments.
  - When x wraps to 0, y increments.
  - After the last beat of line FRAME_LINES-1:
    - frame_done pulses on the next cycle;
    - the block returns to "waiting", and further beats are ignored until frame_start.
- frame_start:
  - Forces x=0 and y=0, enters "active", and arms the sof flag.
  - If raw_valid is high in the same cycle, frame_start wins: that beat is processed as (0,0) of the new frame.
  - A frame_start in the middle of a frame aborts the current frame. Entries already in the FIFO still drain.
- Keep rule: a beat is kept iff all of the following hold:
  - state is active;
  - 2x is in [CROP_X0, CROP_X0+CROP_W);
  - y is in [CROP_Y0, CROP_Y0+CROP_H).
- FIFO push:
  - A kept beat is pushed as {sof, sol, pixel_hi, pixel_lo}.
  - sol = 1 when 2x == CROP_X0.
  - sof = armed flag; the flag is cleared on the first successful push.
- FIFO full:
  - If the FIFO is full when a kept beat arrives, the beat is dropped and overflow is set (cleared only by reset).
  - Counters still advance on a dropped beat.
  - If the dropped beat carried sof, the flag stays armed for the next push.
- Serializer:
  - States: IDLE, PIX_LO, PIX_HI.
  - IDLE → PIX_LO when the FIFO is non-empty: pop one entry and present pixel_lo.
  - The sof/sol markers appear only with pixel_lo; they are 0 with pixel_hi.
  - PIX_LO → PIX_HI on pix_valid && pix_ready.
  - PIX_HI → PIX_LO on handshake if the FIFO is non-empty, popping the next entry in the same cycle; otherwise → IDLE.
  - Sustained throughput is 1 pixel/clk.
- Output stability: pix_data, pix_sof and pix_sol stay stable while pix_valid && !pix_ready.
- Latency: a beat sampled at edge k into an empty FIFO with an idle serializer gives pix_valid high after edge k+2.
- Push and pop in the same cycle are legal; a full FIFO with a simultaneous pop still rejects the push (full is evaluated before the pop).
- Reset mid-frame: everything is flushed immediately, including FIFO contents and overflow.

Test Plan:
- Pixel expansion, LINE_PIXELS=8, FRAME_LINES=2, full crop, pix_ready=1: frame_start, then 8 consecutive beats 0x0100,0x0302,… → 16 pixels 0x000000,0x010101,…,0x0F0F0F in order. pix_sof on pixel 0; pix_sol on pixels 0 and 8; frame_done one cycle after the last beat; first pix_valid 2 cycles after the first beat.
- Crop window, LINE_PIXELS=8, FRAME_LINES=4, CROP_X0=2, CROP_W=4, CROP_Y0=1, CROP_H=2, beat value = {y,x}: exactly 8 pixels out, covering only lines 1–2 and columns 2–5. sol on columns 2 of lines 1 and 2; sof only on line 1, column 2.
- Backpressure, FIFO_DEPTH=4, pix_ready=0 throughout, 6 kept beats: first 4 stored (pix_data held stable); beats 5 and 6 dropped; overflow=1. After releasing pix_ready, exactly 8 pixels emerge.
- Simultaneous frame_start with raw_valid mid-line (x=3): the beat is treated as (0,0), carries sof; the previous frame's partial entries drain first; no frame_done for the aborted frame.
- Beats before the first frame_start and after frame_done: no pushes, pix_valid stays 0.
- Asynchronous reset asserted with the FIFO half-full and the serializer in PIX_HI: all outputs go to 0 with no clock edge; after release, nothing is emitted until a new frame_start plus beats.
